fixed_multiply_seq: RTL and testbench

- Sequential signed fixed-point multiplier with valid/ready handshakes on input and output.
- Processes bits_per_cycle multiplier bits per clock, trading latency for area on the effects datapath.
- Returns a single-width Q-format result with selectable round-half-away-from-zero and saturation, plus an overflow flag.
- Sits between effect stages (gain, tone, mix) where a full combinational multiplier is too costly.

---
 rtl/fixed_math_pkg.sv | 31 +++
 rtl/fixed_round_saturate.sv | 64 ++++++
 rtl/fixed_multiply_seq.sv | 137 +++++++++++++
 tb/tb_fixed_multiply_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_math_pkg.sv
// Shared types and constants for the fixed-point arithmetic blocks.
package fixed_math_pkg;

    // Sequencer states of the multi-cycle multiplier.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Width of the container used to hand saturation limits around.
    localparam int unsigned LIMIT_W = 64;

    // Number of shift-add iterations needed to consume the whole multiplier.
    function automatic int unsigned step_count(input int unsigned op_size,
                                               input int unsigned bpc);
        return op_size / bpc;
    endfunction

    // Magnitude of the most positive signed value of op_size bits.
    function automatic logic [LIMIT_W-1:0] sat_max_mag(input int unsigned op_size);
        return (64'd1 << (op_size - 1)) - 64'd1;
    endfunction

    // Magnitude of the most negative signed value of op_size bits.
    function automatic logic [LIMIT_W-1:0] sat_min_mag(input int unsigned op_size);
        return 64'd1 << (op_size - 1);
    endfunction

endpackage

// File: rtl/fixed_round_saturate.sv
// Combinational finishing stage: round an unsigned double-width magnitude,
// drop the fractional bits, restore the sign, flag overflow and clamp or wrap.
module fixed_round_saturate
    import fixed_math_pkg::*;
#(
    parameter int unsigned operand_size    = 32,
    parameter int unsigned fractional_size = 12
) (
    input  logic [2*operand_size-1:0] mag,
    input  logic                      sign,
    input  logic                      round_en,
    input  logic                      sat_en,
    output logic [operand_size-1:0]   result,
    output logic                      overflow
);

    localparam int unsigned acc_w = 2 * operand_size;
    localparam int unsigned sum_w = acc_w + 1;

    localparam logic [sum_w-1:0] half_lsb = {{acc_w{1'b0}}, 1'b1} << (fractional_size - 1);

    localparam logic [LIMIT_W-1:0] max_full = sat_max_mag(operand_size);
    localparam logic [LIMIT_W-1:0] min_full = sat_min_mag(operand_size);

    // Limits widened to the shifted-sum width so the comparison is exact.
    localparam logic [sum_w-1:0] max_m = sum_w'(max_full);
    localparam logic [sum_w-1:0] min_m = sum_w'(min_full);

    localparam logic [operand_size-1:0] max_c = max_full[operand_size-1:0];
    localparam logic [operand_size-1:0] min_c = min_full[operand_size-1:0];

    logic [sum_w-1:0]        sum_s;
    logic [sum_w-1:0]        m_s;
    logic [operand_size-1:0] m_lo_s;
    logic [operand_size-1:0] r_s;

    // Rounding, scaling, overflow test and clamp/wrap selection.
    always_comb begin
        sum_s  = {1'b0, mag} + (round_en ? half_lsb : {sum_w{1'b0}});
        m_s    = sum_s >> fractional_size;
        m_lo_s = m_s[operand_size-1:0];

        // A negative result may reach one step further than a positive one.
        if (sign) begin
            overflow = (m_s > min_m);
        end else begin
            overflow = (m_s > max_m);
        end

        // Negating a zero magnitude yields zero, so no -0 can appear.
        if (sign) begin
            r_s = -m_lo_s;
        end else begin
            r_s = m_lo_s;
        end

        if (sat_en && overflow) begin
            result = sign ? min_c : max_c;
        end else begin
            result = r_s;
        end
    end

endmodule

// File: rtl/fixed_multiply_seq.sv
// Sequential signed Q-format multiplier: sign-magnitude shift-add over
// bits_per_cycle multiplier bits per clock, with valid/ready on both sides.
module fixed_multiply_seq
    import fixed_math_pkg::*;
#(
    parameter int unsigned operand_size    = 32,
    parameter int unsigned fractional_size = 12,
    parameter int unsigned bits_per_cycle  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [operand_size-1:0] a,
    input  logic [operand_size-1:0] b,
    input  logic                    round_en,
    input  logic                    sat_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [operand_size-1:0] c,
    output logic                    overflow
);

    localparam int unsigned acc_w     = 2 * operand_size;
    localparam int unsigned steps     = step_count(operand_size, bits_per_cycle);
    localparam int unsigned step_w    = $clog2(steps + 1);
    localparam logic [step_w-1:0] last_step = step_w'(steps - 1);

    state_e                  state_r;
    logic [acc_w-1:0]        a_shift_r;
    logic [operand_size-1:0] b_mag_r;
    logic                    sign_r;
    logic                    round_r;
    logic                    sat_r;
    logic [acc_w-1:0]        acc_r;
    logic [step_w-1:0]       step_r;
    logic [operand_size-1:0] c_r;
    logic                    overflow_r;
    logic                    out_valid_r;

    logic [operand_size-1:0] a_mag_s;
    logic [operand_size-1:0] b_mag_s;
    logic                    in_ready_s;
    logic                    accept_s;
    logic [acc_w-1:0]        partial_s;
    logic [operand_size-1:0] fin_c_s;
    logic                    fin_overflow_s;

    // Operand magnitudes, handshake decode and the current partial product.
    always_comb begin
        a_mag_s    = a[operand_size-1] ? -a : a;
        b_mag_s    = b[operand_size-1] ? -b : b;
        in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
        accept_s   = in_valid && in_ready_s;
        // a_shift_r already carries the step*bits_per_cycle weighting.
        partial_s  = a_shift_r * acc_w'(b_mag_r[bits_per_cycle-1:0]);
    end

    fixed_round_saturate #(
        .operand_size    (operand_size),
        .fractional_size (fractional_size)
    ) u_round_sat (
        .mag      (acc_r),
        .sign     (sign_r),
        .round_en (round_r),
        .sat_en   (sat_r),
        .result   (fin_c_s),
        .overflow (fin_overflow_s)
    );

    // Sequencer: accept operands, iterate the shift-add, register the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_shift_r   <= {acc_w{1'b0}};
            b_mag_r     <= {operand_size{1'b0}};
            sign_r      <= 1'b0;
            round_r     <= 1'b0;
            sat_r       <= 1'b0;
            acc_r       <= {acc_w{1'b0}};
            step_r      <= {step_w{1'b0}};
            c_r         <= {operand_size{1'b0}};
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if ((state_r == DONE) && out_ready) begin
                out_valid_r <= 1'b0;
            end

            if (accept_s) begin
                a_shift_r <= {{operand_size{1'b0}}, a_mag_s};
                b_mag_r   <= b_mag_s;
                sign_r    <= a[operand_size-1] ^ b[operand_size-1];
                round_r   <= round_en;
                sat_r     <= sat_en;
                acc_r     <= {acc_w{1'b0}};
                step_r    <= {step_w{1'b0}};
                state_r   <= MUL;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    MUL: begin
                        acc_r     <= acc_r + partial_s;
                        a_shift_r <= a_shift_r << bits_per_cycle;
                        b_mag_r   <= b_mag_r >> bits_per_cycle;
                        step_r    <= step_r + {{(step_w-1){1'b0}}, 1'b1};
                        if (step_r == last_step) begin
                            state_r <= FIN;
                        end
                    end
                    FIN: begin
                        c_r         <= fin_c_s;
                        overflow_r  <= fin_overflow_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                    DONE: begin
                        if (out_ready) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign c         = c_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_fixed_multiply_seq.sv
// Bench for fixed_multiply_seq: directed vectors with literal expectations,
// a signed-arithmetic reference model and a per-cycle output scoreboard.
module tb_fixed_multiply_seq;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        round_en  = 1'b0;
    logic        sat_en    = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a         = 32'd0;
    logic [31:0] b         = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic        overflow;
    logic [31:0] c;

    int checks = 0;
    int errors = 0;
    bit rand_phase = 1'b0;

    typedef struct {
        logic [31:0] c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        r;
        logic        s;
        logic [31:0] c;
        logic        o;
    } vec_t;

    exp_t sb[$];
    vec_t dv[11];

    always #5 clk = ~clk;

    fixed_multiply_seq #(
        .operand_size    (32),
        .fractional_size (12),
        .bits_per_cycle  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .round_en  (round_en),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .overflow  (overflow)
    );

    // Exact signed product, scaled by 2^-12 with truncation or half-away rounding.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mr, input logic ms);
        exp_t   e;
        longint p;
        longint mag;
        longint q;
        longint r;
        p   = longint'($signed(ma)) * longint'($signed(mb));
        mag = (p < 0) ? -p : p;
        q   = mr ? (mag + 64'sd2048) / 64'sd4096 : mag / 64'sd4096;
        r   = (p < 0) ? -q : q;
        e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (ms && e.o) e.c = (r < 0) ? 32'h80000000 : 32'h7FFFFFFF;
        else           e.c = r[31:0];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s bound expired", name);
    endtask

    // Scoreboard: outputs are checked on every valid cycle against the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid actual=1 required=0");
                end else begin
                    chk("sb_c", c, sb[0].c);
                    chk("sb_overflow", 32'(overflow), 32'(sb[0].o));
                end
            end
            if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            if (in_valid && in_ready) sb.push_back(model(a, b, round_en, sat_en));
        end
    end

    // Random consumer stalls during the randomised phase.
    always @(posedge clk) begin
        if (rand_phase) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tr, input logic ts);
        int n;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        round_en = tr;
        sat_en   = ts;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                fail_now("send_in_ready");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    // Counts rising edges from acceptance until out_valid is seen; ends on a falling edge.
    task automatic wait_out(output int edges);
        edges = 0;
        forever begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid) break;
            if (edges > 50) begin
                fail_now("wait_out_valid");
                break;
            end
        end
    endtask

    task automatic run_dir(input vec_t v);
        int e;
        send(v.a, v.b, v.r, v.s);
        wait_out(e);
        chk("latency", 32'(e), 32'd9);
        chk("dir_c", c, v.c);
        chk("dir_overflow", 32'(overflow), 32'(v.o));
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t        m;
        int          e;
        logic signed [31:0] t;
        logic [31:0] ra;
        logic [31:0] rb;

        dv = '{
            '{32'h00001800, 32'h00002000, 1'b0, 1'b0, 32'h00003000, 1'b0},
            '{32'hFFFFE800, 32'h00002000, 1'b0, 1'b0, 32'hFFFFD000, 1'b0},
            '{32'h00000001, 32'h00000800, 1'b0, 1'b0, 32'h00000000, 1'b0},
            '{32'h00000001, 32'h00000800, 1'b1, 1'b0, 32'h00000001, 1'b0},
            '{32'hFFFFFFFF, 32'h00000800, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0},
            '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1},
            '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 32'hFFF00000, 1'b1},
            '{32'h80000000, 32'h00001000, 1'b0, 1'b0, 32'h80000000, 1'b0},
            '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1},
            '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b0},
            '{32'h00000001, 32'h000007FF, 1'b1, 1'b0, 32'h00000000, 1'b0}
        };

        // The reference model must reproduce every hand-computed vector.
        for (int i = 0; i < 11; i++) begin
            m = model(dv[i].a, dv[i].b, dv[i].r, dv[i].s);
            chk("model_c", m.c, dv[i].c);
            chk("model_overflow", 32'(m.o), 32'(dv[i].o));
        end

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c", c, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) run_dir(dv[i]);

        // Backpressure: result held while out_ready is low, then a same-edge handoff.
        out_ready = 1'b0;
        send(32'h00003000, 32'hFFFFF000, 1'b0, 1'b0);
        wait_out(e);
        chk("bp_latency", 32'(e), 32'd9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_c", c, 32'hFFFFD000);
            chk("bp_hold_overflow", 32'(overflow), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 32'h00002800;
        b         = 32'h00002800;
        round_en  = 1'b0;
        sat_en    = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(e);
        chk("bp2_latency", 32'(e), 32'd9);
        chk("bp2_c", c, 32'h00006400);
        chk("bp2_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of the shift-add abandons the transaction.
        send(32'h00001800, 32'h00002000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_c", c, 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_dir('{32'h00004000, 32'hFFFFF800, 1'b0, 1'b0, 32'hFFFFE000, 1'b0});

        // Randomised traffic with consumer stalls, checked by the scoreboard.
        rand_phase = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            t  = $urandom;
            ra = t >>> $urandom_range(0, 31);
            t  = $urandom;
            rb = t >>> $urandom_range(0, 31);
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_phase = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        e = 0;
        while ((sb.size() != 0 || out_valid) && e < 200) begin
            @(negedge clk);
            e++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
